// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between fetch and data ports; data wins, the just-served port is masked for one round.
// Ready pulses two cycles after a request is sampled; requesters stall by holding req until their ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERRR} state_t;

  state_t state, state_nx;
  logic   served_d;
  logic   err_pend;
  logic   resp_like, arb_en;
  logic   d_cand, f_cand;
  logic   grant_d, grant_f, grant, grant_err;
  logic   d_mis, f_mis;

  // The port answered in RESP/ERRR is masked so a still-high req cannot win twice in a row.
  always_comb begin
    resp_like = (state == RESP) || (state == ERRR);
    arb_en    = (state == IDLE) || resp_like;
    d_cand    = d_req && !(resp_like && served_d);
    f_cand    = if_req && !(resp_like && !served_d);
    grant_d   = arb_en && d_cand;
    grant_f   = arb_en && !d_cand && f_cand;
    grant     = grant_d || grant_f;
    f_mis     = |if_addr[1:0];
    if (d_funct3[1])      d_mis = |d_addr[1:0];
    else if (d_funct3[0]) d_mis = d_addr[0];
    else                  d_mis = 1'b0;
    grant_err = grant_d ? d_mis : f_mis;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    if_err   = 1'b0;
    d_err    = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:   if (grant) state_nx = ACCESS;
      // A misaligned grant still spends one ACCESS cycle, strobes low, so ready timing is uniform.
      ACCESS: state_nx = err_pend ? ERRR : RESP;
      RESP, ERRR: begin
        if_ready = !served_d;
        d_ready  = served_d;
        if_err   = (state == ERRR) && !served_d;
        d_err    = (state == ERRR) && served_d;
        state_nx = grant ? ACCESS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_funct3 <= '0;
      mem_wdata  <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      served_d   <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      if (state == ACCESS) begin
        if (mem_re) begin
          if (served_d) d_rdata  <= mem_rdata;
          else          if_rdata <= mem_rdata;
        end
        mem_re <= 1'b0;
        mem_we <= 1'b0;
      end
      if (grant) begin
        served_d <= grant_d;
        err_pend <= grant_err;
        if (!grant_err) begin
          if (grant_d) begin
            mem_addr   <= d_addr;
            mem_funct3 <= d_funct3;
            mem_wdata  <= d_wdata;
            mem_re     <= !d_we;
            mem_we     <= d_we;
          end else begin
            mem_addr   <= if_addr;
            mem_funct3 <= F3_WORD;
            mem_re     <= 1'b1;
            mem_we     <= 1'b0;
          end
        end
      end
    end
  end

endmodule
